// File: rtl/reg_file_sb_pkg.sv
// Shared constants for the pipelined-core register file: immediate
// extension mode encodings and the default core datapath geometry.
package reg_file_sb_pkg;

    localparam logic [1:0] IMM_SEXT_FULL = 2'd0;
    localparam logic [1:0] IMM_SEXT3     = 2'd1;
    localparam logic [1:0] IMM_ZEXT      = 2'd2;
    localparam logic [1:0] IMM_RSVD      = 2'd3;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_DEPTH  = 8;
    localparam int DEFAULT_IMM_W  = 6;

endpackage

// File: rtl/reg_file_sb_imm_extend.sv
// Immediate sign/zero extension. Built at the wider of DATA_W and IMM_W,
// then truncated to DATA_W, so narrow datapaths keep the low bits.
module imm_extend
    import reg_file_sb_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int IMM_W  = DEFAULT_IMM_W
) (
    input  logic [IMM_W-1:0]  imm_raw,
    input  logic [1:0]        imm_mode,
    output logic [DATA_W-1:0] imm_data
);

    localparam int EXT_W = (DATA_W > IMM_W) ? DATA_W : IMM_W;

    logic [EXT_W-1:0] raw_z;
    logic [EXT_W-1:0] sext_full;
    logic [EXT_W-1:0] sext3;
    logic [EXT_W-1:0] ext_sel;

    // Form every extension candidate, then pick one by mode; the upper-bit
    // mask collapses to zero when there are no bits above the raw field.
    always_comb begin
        raw_z     = EXT_W'(imm_raw);
        sext_full = raw_z | (imm_raw[IMM_W-1] ? ~((EXT_W'(1) << IMM_W) - EXT_W'(1)) : '0);
        sext3     = EXT_W'(imm_raw[2:0]) | (imm_raw[2] ? ~EXT_W'(3'b111) : '0);
        case (imm_mode)
            IMM_SEXT_FULL: ext_sel = sext_full;
            IMM_SEXT3:     ext_sel = sext3;
            IMM_ZEXT:      ext_sel = raw_z;
            default:       ext_sel = '0;
        endcase
        imm_data = ext_sel[DATA_W-1:0];
    end

endmodule

// File: rtl/reg_file_sb.sv
// Register file with two combinational read ports, one write port,
// write-to-read bypass, optional hardwired zero register and a busy
// scoreboard that reports read-after-write hazards to issue.
module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int ADDR_W     = $clog2(DEPTH),
    parameter int IMM_W      = DEFAULT_IMM_W,
    parameter int ZERO_REG   = 0,
    parameter int INIT_INDEX = 1
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [ADDR_W-1:0] Rd_Addr_A,
    input  logic [ADDR_W-1:0] Rd_Addr_B,
    output logic [DATA_W-1:0] Rd_Data_A,
    output logic [DATA_W-1:0] Rd_Data_B,
    input  logic              Wr_En,
    input  logic [ADDR_W-1:0] Wr_Addr,
    input  logic [DATA_W-1:0] Wr_Data,
    input  logic              Issue_En,
    input  logic [ADDR_W-1:0] Issue_Dest,
    output logic              Hazard_A,
    output logic              Hazard_B,
    output logic [DEPTH-1:0]  Busy_Vec,
    input  logic [IMM_W-1:0]  Imm_Raw,
    input  logic [1:0]        Imm_Mode,
    output logic [DATA_W-1:0] Imm_Data
);

    localparam bit ZERO_EN = (ZERO_REG != 0);
    localparam bit INIT_EN = (INIT_INDEX != 0);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;

    logic wr_ok;
    logic iss_ok;
    logic byp_a;
    logic byp_b;

    // Qualify write/issue against the zero register and detect bypass hits.
    always_comb begin
        wr_ok  = Wr_En && !(ZERO_EN && (Wr_Addr == '0));
        iss_ok = Issue_En && !(ZERO_EN && (Issue_Dest == '0));
        byp_a  = wr_ok && (Wr_Addr == Rd_Addr_A);
        byp_b  = wr_ok && (Wr_Addr == Rd_Addr_B);
    end

    // Next register contents: a single qualified write.
    always_comb begin
        regs_d = regs_q;
        if (wr_ok) begin
            regs_d[Wr_Addr] = Wr_Data;
        end
    end

    // Next scoreboard: writeback clears, then issue sets so a new producer
    // to the same register wins over the retiring one.
    always_comb begin
        busy_d = busy_q;
        if (Wr_En) begin
            busy_d[Wr_Addr] = 1'b0;
        end
        if (iss_ok) begin
            busy_d[Issue_Dest] = 1'b1;
        end
    end

    // Read ports with bypass; a same-cycle writeback resolves the hazard.
    always_comb begin
        Rd_Data_A = byp_a ? Wr_Data : regs_q[Rd_Addr_A];
        Rd_Data_B = byp_b ? Wr_Data : regs_q[Rd_Addr_B];
        Hazard_A  = busy_q[Rd_Addr_A] & ~byp_a;
        Hazard_B  = busy_q[Rd_Addr_B] & ~byp_b;
        Busy_Vec  = busy_q;
    end

    // Storage and scoreboard state; reset loads index values (reg0 is 0
    // either way) and clears all pending bits.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= INIT_EN ? DATA_W'(i) : '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    imm_extend #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W)
    ) u_imm_extend (
        .imm_raw  (Imm_Raw),
        .imm_mode (Imm_Mode),
        .imm_data (Imm_Data)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench: stimulus queues expected values and fires a check
// event; a monitor process pops the queue and compares live outputs.
module tb_reg_file_sb;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic [2:0] Rd_Addr_A, Rd_Addr_B, Wr_Addr, Issue_Dest;
    logic [7:0] Wr_Data;
    logic       Wr_En, Issue_En;
    logic [5:0] Imm_Raw;
    logic [1:0] Imm_Mode;

    logic [7:0] rda0, rdb0, busy0, imm0;
    logic       haza0, hazb0;
    logic [7:0] rda1, rdb1, busy1, imm1;
    logic       haza1, hazb1;

    always #5 Clk = ~Clk;

    reg_file_sb u0 (
        .Clk(Clk), .Reset_n(Reset_n),
        .Rd_Addr_A(Rd_Addr_A), .Rd_Addr_B(Rd_Addr_B),
        .Rd_Data_A(rda0), .Rd_Data_B(rdb0),
        .Wr_En(Wr_En), .Wr_Addr(Wr_Addr), .Wr_Data(Wr_Data),
        .Issue_En(Issue_En), .Issue_Dest(Issue_Dest),
        .Hazard_A(haza0), .Hazard_B(hazb0), .Busy_Vec(busy0),
        .Imm_Raw(Imm_Raw), .Imm_Mode(Imm_Mode), .Imm_Data(imm0)
    );

    reg_file_sb #(.ZERO_REG(1)) u1 (
        .Clk(Clk), .Reset_n(Reset_n),
        .Rd_Addr_A(Rd_Addr_A), .Rd_Addr_B(Rd_Addr_B),
        .Rd_Data_A(rda1), .Rd_Data_B(rdb1),
        .Wr_En(Wr_En), .Wr_Addr(Wr_Addr), .Wr_Data(Wr_Data),
        .Issue_En(Issue_En), .Issue_Dest(Issue_Dest),
        .Hazard_A(haza1), .Hazard_B(hazb1), .Busy_Vec(busy1),
        .Imm_Raw(Imm_Raw), .Imm_Mode(Imm_Mode), .Imm_Data(imm1)
    );

    localparam int S_RDA0 = 0, S_RDB0 = 1, S_HZA0 = 2, S_HZB0 = 3, S_BSY0 = 4;
    localparam int S_IMM0 = 5, S_RDA1 = 6, S_HZA1 = 7, S_BSY1 = 8, S_IMM1 = 9;

    typedef struct {
        int          sel;
        string       nm;
        logic [31:0] exp;
    } exp_t;

    exp_t exp_q[$];
    event chk_ev;
    int   total = 0;
    int   bad   = 0;

    function automatic logic [31:0] get_act(int sel);
        case (sel)
            S_RDA0:  return {24'd0, rda0};
            S_RDB0:  return {24'd0, rdb0};
            S_HZA0:  return {31'd0, haza0};
            S_HZB0:  return {31'd0, hazb0};
            S_BSY0:  return {24'd0, busy0};
            S_IMM0:  return {24'd0, imm0};
            S_RDA1:  return {24'd0, rda1};
            S_HZA1:  return {31'd0, haza1};
            S_BSY1:  return {24'd0, busy1};
            default: return {24'd0, imm1};
        endcase
    endfunction

    // Monitor: on each check event, drain the queue against live outputs.
    initial begin
        exp_t e;
        logic [31:0] act;
        forever begin
            @(chk_ev);
            while (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = get_act(e.sel);
                total++;
                if (act !== e.exp) begin
                    bad++;
                    $display("FAIL %s: got %0h expected %0h", e.nm, act, e.exp);
                end
            end
        end
    end

    task automatic expect_v(int sel, string nm, logic [31:0] v);
        exp_q.push_back('{sel, nm, v});
    endtask

    task automatic check_now();
        -> chk_ev;
        #1;
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset_n = 1'b1; Rd_Addr_A = 3'd5; Rd_Addr_B = 3'd0;
        Wr_En = 1'b0; Wr_Addr = '0; Wr_Data = '0;
        Issue_En = 1'b0; Issue_Dest = '0;
        Imm_Raw = '0; Imm_Mode = 2'd0;

        // 1: reset asserted mid-cycle; reads reflect reset contents
        #7 Reset_n = 1'b0;
        #1;
        expect_v(S_RDA0, "rst_rda_idx5", 32'h05);
        expect_v(S_RDB0, "rst_rdb_idx0", 32'h00);
        expect_v(S_BSY0, "rst_busy",     32'h00);
        expect_v(S_HZA0, "rst_haza",     32'h0);
        expect_v(S_RDA1, "rst_rda_zr",   32'h05);
        expect_v(S_BSY1, "rst_busy_zr",  32'h00);
        check_now();
        @(negedge Clk);
        Reset_n = 1'b1;
        Rd_Addr_A = 3'd3;
        Wr_En = 1'b1; Wr_Addr = 3'd3; Wr_Data = 8'hA5;
        #1;
        expect_v(S_RDA0, "wr3_bypass", 32'hA5);
        check_now();
        cyc();
        Wr_En = 1'b0; Rd_Addr_B = 3'd3;
        #1;
        expect_v(S_RDA0, "wr3_stored_a", 32'hA5);
        expect_v(S_RDB0, "wr3_stored_b", 32'hA5);
        check_now();

        // 2: both ports bypass the same register
        Rd_Addr_A = 3'd2; Rd_Addr_B = 3'd2;
        #1;
        expect_v(S_RDA0, "reg2_init", 32'h02);
        check_now();
        Wr_En = 1'b1; Wr_Addr = 3'd2; Wr_Data = 8'h3C;
        #1;
        expect_v(S_RDA0, "dual_byp_a", 32'h3C);
        expect_v(S_RDB0, "dual_byp_b", 32'h3C);
        check_now();
        cyc();
        Wr_En = 1'b0;
        #1;
        expect_v(S_RDA0, "reg2_held_a", 32'h3C);
        expect_v(S_RDB0, "reg2_held_b", 32'h3C);
        check_now();

        // 3: issue sets busy, writeback resolves hazard through bypass
        Issue_En = 1'b1; Issue_Dest = 3'd4;
        cyc();
        Issue_En = 1'b0; Rd_Addr_B = 3'd4;
        #1;
        expect_v(S_BSY0, "iss4_busy",  32'h10);
        expect_v(S_HZB0, "iss4_hazb",  32'h1);
        expect_v(S_RDB0, "iss4_stale", 32'h04);
        check_now();
        Wr_En = 1'b1; Wr_Addr = 3'd4; Wr_Data = 8'h77;
        #1;
        expect_v(S_HZB0, "wb4_hazb_clr", 32'h0);
        expect_v(S_RDB0, "wb4_bypass",   32'h77);
        check_now();
        cyc();
        Wr_En = 1'b0;
        #1;
        expect_v(S_BSY0, "wb4_busy_clr", 32'h00);
        expect_v(S_HZB0, "wb4_hazb_after", 32'h0);
        check_now();

        // 4: set beats clear on the same register; distinct targets both apply
        Issue_En = 1'b1; Issue_Dest = 3'd6;
        cyc();
        Issue_En = 1'b0;
        #1;
        expect_v(S_BSY0, "iss6_busy", 32'h40);
        check_now();
        Issue_En = 1'b1; Issue_Dest = 3'd6;
        Wr_En = 1'b1; Wr_Addr = 3'd6; Wr_Data = 8'h11;
        cyc();
        expect_v(S_BSY0, "set_wins", 32'h40);
        check_now();
        Issue_Dest = 3'd1; Wr_Data = 8'h22;
        cyc();
        Issue_En = 1'b0; Wr_En = 1'b0; Rd_Addr_A = 3'd6;
        #1;
        expect_v(S_BSY0, "iss1_wb6", 32'h02);
        expect_v(S_RDA0, "reg6_val", 32'h22);
        expect_v(S_BSY1, "iss1_wb6_zr", 32'h02);
        check_now();

        // 5: zero register ignores writes and issues (u1), normal reg0 in u0
        Rd_Addr_A = 3'd0;
        Issue_En = 1'b1; Issue_Dest = 3'd0;
        Wr_En = 1'b1; Wr_Addr = 3'd0; Wr_Data = 8'hFF;
        #1;
        expect_v(S_RDA1, "zr_no_bypass", 32'h00);
        expect_v(S_HZA1, "zr_haza_live", 32'h0);
        expect_v(S_RDA0, "r0_bypass",    32'hFF);
        check_now();
        cyc();
        Issue_En = 1'b0; Wr_En = 1'b0;
        #1;
        expect_v(S_RDA1, "zr_read0",  32'h00);
        expect_v(S_HZA1, "zr_haza",   32'h0);
        expect_v(S_BSY1, "zr_busy",   32'h02);
        expect_v(S_BSY0, "r0_busy",   32'h03);
        expect_v(S_HZA0, "r0_haza",   32'h1);
        expect_v(S_RDA0, "r0_stored", 32'hFF);
        check_now();

        // 6: immediate extension modes
        Imm_Raw = 6'b101011;
        Imm_Mode = 2'd0; #1; expect_v(S_IMM0, "imm_sext_full", 32'hEB); check_now();
        Imm_Mode = 2'd1; #1; expect_v(S_IMM0, "imm_sext3_pos", 32'h03); check_now();
        Imm_Mode = 2'd2; #1; expect_v(S_IMM0, "imm_zext",      32'h2B); check_now();
        Imm_Mode = 2'd3; #1; expect_v(S_IMM0, "imm_rsvd",      32'h00); check_now();
        Imm_Raw = 6'b000100;
        Imm_Mode = 2'd1; #1; expect_v(S_IMM0, "imm_sext3_neg", 32'hFC); check_now();
        Imm_Raw = 6'b011111;
        Imm_Mode = 2'd0; #1; expect_v(S_IMM1, "imm_sext_full_pos", 32'h1F); check_now();

        #2;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
